axis_elastic_buffer: RTL and testbench



---
 rtl/axis_elastic_buffer.sv | 123 ++++++++++++
 tb/tb_axis_elastic_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axis_elastic_buffer.sv
// AXI-Stream elastic buffer: DEPTH-entry circular register FIFO with registered
// handshake outputs and a synchronous flush that discards every stored beat.
module axis_elastic_buffer #(
    parameter  int TDATA_WIDTH = 32,
    parameter  int TUSER_WIDTH = 1,
    parameter  int DEPTH       = 2,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic [TUSER_WIDTH-1:0] s_tuser,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic [TUSER_WIDTH-1:0] m_tuser,
    output logic                   m_tlast,
    input  logic                   flush,
    output logic [CNT_W-1:0]       count
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = TDATA_WIDTH + TUSER_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TDATA_WIDTH < 1 || TUSER_WIDTH < 1) begin : g_bad_param
            $fatal(1, "axis_elastic_buffer: DEPTH must be a power of two >= 2 and widths > 0");
        end
    endgenerate

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               m_tvalid_reg, m_tvalid_next;
    logic               s_tready_reg, s_tready_next;
    logic [DEPTH-1:0]   wr_en;
    logic [ENTRY_W-1:0] s_entry;
    logic [ENTRY_W-1:0] m_entry;
    logic               push;
    logic               pop;

    assign push    = s_tvalid && s_tready_reg;
    assign pop     = m_tvalid_reg && m_tready;
    assign s_entry = {s_tlast, s_tuser, s_tdata};

    // A beat accepted during flush is dropped, so it is never written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && !flush && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= s_entry;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (!push && pop) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
        m_tvalid_next = (count_next != '0);
        s_tready_next = (count_next != FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            m_tvalid_reg <= 1'b0;
            s_tready_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            m_tvalid_reg <= m_tvalid_next;
            s_tready_reg <= s_tready_next;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign m_entry  = m_tvalid_reg ? mem_reg[rd_ptr_reg] : '0;
    assign m_tdata  = m_entry[TDATA_WIDTH-1:0];
    assign m_tuser  = m_entry[TDATA_WIDTH +: TUSER_WIDTH];
    assign m_tlast  = m_entry[ENTRY_W-1];
    assign m_tvalid = m_tvalid_reg;
    assign s_tready = s_tready_reg;
    assign count    = count_reg;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n) push |-> (count_reg != FULL_CNT))
        else $error("push accepted while full");
    assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count_reg != '0))
        else $error("pop taken while empty");
    assert property (@(posedge clk) disable iff (!rst_n)
        $past(m_tvalid_reg && !m_tready && !flush) |-> $stable(m_entry))
        else $error("manager payload changed while stalled");
`endif

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Directed bench for axis_elastic_buffer (DEPTH=4) with a queue reference model.
module tb_axis_elastic_buffer;
    localparam int DW    = 32;
    localparam int UW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = DW + UW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic [UW-1:0] s_tuser;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          flush;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    axis_elastic_buffer #(
        .TDATA_WIDTH(DW),
        .TUSER_WIDTH(UW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata (s_tdata),
        .s_tuser (s_tuser),
        .s_tlast (s_tlast),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .m_tuser (m_tuser),
        .m_tlast (m_tlast),
        .flush   (flush),
        .count   (count)
    );

    logic [EW-1:0] q[$];
    int            checks = 0;
    int            errors = 0;
    logic          acc;
    int            k;
    logic [DW-1:0] rd;
    logic [UW-1:0] ru;
    logic          rl;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides push/pop from its own occupancy.
    task automatic step_beat(input logic sv, input logic [DW-1:0] d, input logic [UW-1:0] u,
                             input logic l, input logic mr, input logic fl, output logic accepted);
        logic          pop;
        logic [EW-1:0] exp_head;
        s_tvalid = sv;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        m_tready = mr;
        flush    = fl;
        accepted = sv && (q.size() != DEPTH);
        pop      = mr && (q.size() != 0);
        exp_head = (q.size() != 0) ? q[0] : '0;
        check_eq("m_beat", 64'({m_tlast, m_tuser, m_tdata}), 64'(exp_head));
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (fl) q.delete();
        else if (accepted) q.push_back({l, u, d});
        check_eq("count", 64'(count), 64'(q.size()));
        check_eq("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
        check_eq("s_tready", 64'(s_tready), 64'(q.size() != DEPTH));
        $display("beat sv=%0b d=0x%0h mr=%0b fl=%0b acc=%0b count=%0d", sv, d, mr, fl, accepted, count);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_s_tready", 64'(s_tready), 64'd0);
        check_eq("rst_m_beat", 64'({m_tlast, m_tuser, m_tdata}), 64'd0);
        rst_n = 1'b1;
        step_beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);

        // Single beat: visible the cycle after its push.
        step_beat(1'b1, 32'h10, 2'd1, 1'b0, 1'b0, 1'b0, acc);
        check_eq("lat_m_tvalid", 64'(m_tvalid), 64'd1);
        check_eq("lat_m_tdata", 64'(m_tdata), 64'h10);
        step_beat(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Back-to-back with an always-ready manager.
        for (int i = 0; i < 8; i++) begin
            step_beat(1'b1, 32'(32'h20 + i), 2'(i), (i == 7), 1'b1, 1'b0, acc);
            check_eq("b2b_cnt_le1", 64'(count <= CW'(1)), 64'd1);
        end
        step_beat(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Fill against a stalled manager: only four beats fit.
        for (int i = 0; i < 6; i++) begin
            step_beat(1'b1, 32'(32'hA0 + ((i < 4) ? i : 4)), 2'(i), 1'b0, 1'b0, 1'b0, acc);
            check_eq("fill_s_tready", 64'(s_tready), 64'(i < 3));
        end
        check_eq("fill_count", 64'(count), 64'd4);
        check_eq("fill_head", 64'(m_tdata), 64'hA0);
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_order", 64'(m_tdata), 64'(32'hA0 + i));
            step_beat(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
            if (i == 0) check_eq("drain_s_tready", 64'(s_tready), 64'd1);
        end

        // Full buffer with continuous pop and offered data; pointers wrap.
        for (int i = 0; i < 4; i++) begin
            step_beat(1'b1, 32'(32'hC0 + i), 2'(i), i[0], 1'b0, 1'b0, acc);
        end
        k = 4;
        for (int n = 0; n < 14; n++) begin
            step_beat(1'b1, 32'(32'hC0 + k), 2'(k), k[0], 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        check_eq("wrap_pushes", 64'(k), 64'd17);
        repeat (4) step_beat(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Flush with a concurrent push and pop.
        for (int i = 0; i < 3; i++) begin
            step_beat(1'b1, 32'(32'hD0 + i), '0, 1'b0, 1'b0, 1'b0, acc);
        end
        step_beat(1'b1, 32'h55, 2'd3, 1'b1, 1'b1, 1'b1, acc);
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("flush_s_tready", 64'(s_tready), 64'd1);
        step_beat(1'b1, 32'h66, 2'd0, 1'b1, 1'b0, 1'b0, acc);
        check_eq("post_flush_head", 64'(m_tdata), 64'h66);
        step_beat(1'b1, 32'h67, 2'd1, 1'b0, 1'b0, 1'b0, acc);

        // Asynchronous reset between edges with two beats stored.
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("arst_s_tready", 64'(s_tready), 64'd0);
        check_eq("arst_m_beat", 64'({m_tlast, m_tuser, m_tdata}), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        check_eq("arst_hold_s_tready", 64'(s_tready), 64'd0);
        rst_n = 1'b1;
        step_beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        step_beat(1'b1, 32'h77, 2'd2, 1'b1, 1'b0, 1'b0, acc);
        check_eq("arst_after_head", 64'(m_tdata), 64'h77);
        step_beat(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Random valid/ready; offered beat is held until accepted.
        rd = $urandom;
        ru = 2'($urandom);
        rl = 1'($urandom);
        for (int n = 0; n < 400; n++) begin
            step_beat(1'($urandom_range(0, 1)), rd, ru, rl, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 31) == 0), acc);
            if (acc) begin
                rd = $urandom;
                ru = 2'($urandom);
                rl = 1'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
